// File: rtl/rcp_pkg.sv
// rtl/rcp_pkg.sv - shared Q-format constants and state encoding for the reciprocal pair sequencer
package rcp_pkg;

    localparam int RCP_M = 12;
    localparam int RCP_N = 12;
    localparam int RCP_W = RCP_M + RCP_N;

    // Largest positive Q value: sign bit clear, every other bit set.
    localparam logic [RCP_W-1:0] RCP_MAX_POS = {1'b0, {(RCP_W-1){1'b1}}};

    localparam int RCP_TIMEOUT_DEF = 64;

    typedef enum logic [2:0] {
        SEQ_IDLE    = 3'd0,
        SEQ_ISSUE_X = 3'd1,
        SEQ_WAIT_X  = 3'd2,
        SEQ_ISSUE_Y = 3'd3,
        SEQ_WAIT_Y  = 3'd4,
        SEQ_DONE    = 3'd5
    } rcp_seq_state_e;

endpackage

// File: rtl/rcp_pair_sequencer.sv
// rtl/rcp_pair_sequencer.sv - feeds X then Y through one shared reciprocal engine; optional watchdog under RCP_SEQ_TIMEOUT_EN
module rcp_pair_sequencer
    import rcp_pkg::*;
#(
    parameter int M       = RCP_M,
    parameter int N       = RCP_N,
    parameter bit ABS     = 1'b1,
    parameter int TIMEOUT = RCP_TIMEOUT_DEF
) (
    input  logic           i_clk,
    input  logic           i_reset_n,
    input  logic           i_start,
    input  logic [M+N-1:0] i_x,
    input  logic [M+N-1:0] i_y,
    output logic           o_busy,
    output logic [M+N-1:0] o_rcp_x,
    output logic [M+N-1:0] o_rcp_y,
    output logic           o_sat_x,
    output logic           o_sat_y,
    output logic           o_done,
    output logic           o_timeout,
    output logic           o_eng_start,
    output logic [M+N-1:0] o_eng_data,
    output logic           o_eng_abs,
    input  logic [M+N-1:0] i_eng_data,
    input  logic           i_eng_sat,
    input  logic           i_eng_done
);

    localparam int W = M + N;
    localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};

    // A zero watchdog limit would fire before the engine could ever answer.
    if (TIMEOUT < 1) begin : g_timeout_range
        $error("rcp_pair_sequencer: TIMEOUT must be at least 1");
    end

    rcp_seq_state_e state_q, state_d;
    logic [W-1:0]   x_q, y_q;
    logic           accept;
    logic           wd_fire;

    assign accept = i_start && ((state_q == SEQ_IDLE) || (state_q == SEQ_DONE));

`ifdef RCP_SEQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wd_cnt_q;
    logic          timeout_q;

    // Watchdog counter: cleared in the ISSUE cycle so it reads 0 on WAIT entry.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wd_cnt_q <= '0;
        end else if ((state_q == SEQ_ISSUE_X) || (state_q == SEQ_ISSUE_Y)) begin
            wd_cnt_q <= '0;
        end else if ((state_q == SEQ_WAIT_X) || (state_q == SEQ_WAIT_Y)) begin
            wd_cnt_q <= wd_cnt_q + CW'(1);
        end
    end

    assign wd_fire = ((state_q == SEQ_WAIT_X) || (state_q == SEQ_WAIT_Y)) &&
                     !i_eng_done && (wd_cnt_q == CW'(TIMEOUT - 1));

    // Timeout pulse lines up with the forced result becoming visible.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= wd_fire;
        end
    end

    assign o_timeout = timeout_q;
`else
    assign wd_fire   = 1'b0;
    assign o_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= SEQ_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; engine done only matters in the WAIT states.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SEQ_IDLE:    if (accept) state_d = SEQ_ISSUE_X;
            SEQ_ISSUE_X: state_d = SEQ_WAIT_X;
            SEQ_WAIT_X:  if (i_eng_done || wd_fire) state_d = SEQ_ISSUE_Y;
            SEQ_ISSUE_Y: state_d = SEQ_WAIT_Y;
            SEQ_WAIT_Y:  if (i_eng_done || wd_fire) state_d = SEQ_DONE;
            SEQ_DONE:    state_d = accept ? SEQ_ISSUE_X : SEQ_IDLE;
            default:     state_d = SEQ_IDLE;
        endcase
    end

    // Operand latch: only a request accepted in IDLE or DONE overwrites it.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            x_q <= '0;
            y_q <= '0;
        end else if (accept) begin
            x_q <= i_x;
            y_q <= i_y;
        end
    end

    // Result capture: each result moves only on its own done or watchdog edge.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_rcp_x <= '0;
            o_sat_x <= 1'b0;
            o_rcp_y <= '0;
            o_sat_y <= 1'b0;
        end else begin
            if (state_q == SEQ_WAIT_X) begin
                if (i_eng_done) begin
                    o_rcp_x <= i_eng_data;
                    o_sat_x <= i_eng_sat;
                end else if (wd_fire) begin
                    o_rcp_x <= MAX_POS;
                    o_sat_x <= 1'b1;
                end
            end
            if (state_q == SEQ_WAIT_Y) begin
                if (i_eng_done) begin
                    o_rcp_y <= i_eng_data;
                    o_sat_y <= i_eng_sat;
                end else if (wd_fire) begin
                    o_rcp_y <= MAX_POS;
                    o_sat_y <= 1'b1;
                end
            end
        end
    end

    // Engine-facing and status outputs decode straight from the state register.
    always_comb begin
        o_eng_data = '0;
        case (state_q)
            SEQ_ISSUE_X, SEQ_WAIT_X: o_eng_data = x_q;
            SEQ_ISSUE_Y, SEQ_WAIT_Y: o_eng_data = y_q;
            default:                 o_eng_data = '0;
        endcase
    end

    assign o_eng_start = (state_q == SEQ_ISSUE_X) || (state_q == SEQ_ISSUE_Y);
    assign o_busy      = (state_q == SEQ_ISSUE_X) || (state_q == SEQ_WAIT_X) ||
                         (state_q == SEQ_ISSUE_Y) || (state_q == SEQ_WAIT_Y);
    assign o_done      = (state_q == SEQ_DONE);
    assign o_eng_abs   = ABS;

endmodule

// File: tb/tb_rcp_pair_sequencer.sv
// tb/tb_rcp_pair_sequencer.sv - randomized self-checking bench for rcp_pair_sequencer with a behavioural engine
module tb_rcp_pair_sequencer;
    import rcp_pkg::*;

    localparam int W = RCP_W;
`ifdef RCP_SEQ_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 64;
`endif

    logic         i_clk = 1'b0;
    logic         i_reset_n, i_start, i_eng_sat, i_eng_done;
    logic [W-1:0] i_x, i_y, i_eng_data;
    logic         o_busy, o_sat_x, o_sat_y, o_done, o_timeout, o_eng_start, o_eng_abs;
    logic [W-1:0] o_rcp_x, o_rcp_y, o_eng_data;

    rcp_pair_sequencer #(.M(RCP_M), .N(RCP_N), .ABS(1'b1), .TIMEOUT(TO)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_start(i_start), .i_x(i_x), .i_y(i_y),
        .o_busy(o_busy), .o_rcp_x(o_rcp_x), .o_rcp_y(o_rcp_y), .o_sat_x(o_sat_x),
        .o_sat_y(o_sat_y), .o_done(o_done), .o_timeout(o_timeout), .o_eng_start(o_eng_start),
        .o_eng_data(o_eng_data), .o_eng_abs(o_eng_abs), .i_eng_data(i_eng_data),
        .i_eng_sat(i_eng_sat), .i_eng_done(i_eng_done)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    // Expected architectural results, maintained by the bench.
    logic [W-1:0] m_rx, m_ry;
    logic         m_sx, m_sy;

    // Pulse monitor.
    int   n_start = 0, n_done = 0, n_consec = 0, n_timeout = 0;
    logic prev_start = 1'b0;
    always @(negedge i_clk) begin
        if (o_eng_start) begin
            n_start <= n_start + 1;
            if (prev_start) n_consec <= n_consec + 1;
        end
        prev_start <= o_eng_start;
        if (o_done) n_done <= n_done + 1;
        if (o_timeout) n_timeout <= n_timeout + 1;
    end

    // Reference reciprocal engine: 2^(2N)/|x|, saturating at max positive.
    function automatic logic [W:0] eng_model(input logic [W-1:0] v);
        longint a, q;
        logic [W-1:0] r;
        a = $signed(v);
        if (a < 0) a = -a;
        if (a == 0) return {1'b1, RCP_MAX_POS};
        q = (longint'(1) << (2 * RCP_N)) / a;
        if (q > longint'(RCP_MAX_POS)) return {1'b1, RCP_MAX_POS};
        r = q[W-1:0];
        return {1'b0, r};
    endfunction

    // One full request, acting as the engine; called at a negedge, returns at the DONE negedge.
    task automatic do_req(input logic [W-1:0] x, input logic [W-1:0] y, input int lx, input int ly,
                          input bit hold, input bit stale, input string tag);
        logic [W:0] ex, ey;
        int cyc;
        ex = eng_model(x);
        ey = eng_model(y);
        i_x = x; i_y = y; i_start = 1'b1; cyc = 0;
        @(negedge i_clk); cyc++;
        if (!hold) i_start = 1'b0;
        else begin i_x = W'($urandom); i_y = W'($urandom); end
        checks++;
        if (o_eng_start !== 1'b1 || o_eng_data !== x || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL %s issue_x: start=%0b data=%h busy=%0b required start=1 data=%h busy=1", tag, o_eng_start, o_eng_data, o_busy, x);
        end
        if (stale) begin i_eng_done = 1'b1; i_eng_data = W'($urandom); i_eng_sat = 1'b1; end
        repeat (lx) begin
            @(negedge i_clk); cyc++;
            i_eng_done = 1'b0;
            if (hold) i_x = W'($urandom);
            checks++;
            if (o_eng_start !== 1'b0 || o_eng_data !== x || o_rcp_x !== m_rx || o_sat_x !== m_sx) begin
                errors++;
                $display("FAIL %s wait_x: start=%0b data=%h rcp_x=%h sat_x=%0b required 0 %h %h %0b", tag, o_eng_start, o_eng_data, o_rcp_x, o_sat_x, x, m_rx, m_sx);
            end
        end
        i_eng_done = 1'b1; i_eng_data = ex[W-1:0]; i_eng_sat = ex[W];
        @(negedge i_clk); cyc++;
        i_eng_done = 1'b0; i_eng_data = W'($urandom); i_eng_sat = 1'($urandom);
        m_rx = ex[W-1:0]; m_sx = ex[W];
        checks++;
        if (o_eng_start !== 1'b1 || o_eng_data !== y || o_rcp_x !== m_rx || o_sat_x !== m_sx) begin
            errors++;
            $display("FAIL %s issue_y: start=%0b data=%h rcp_x=%h sat_x=%0b required 1 %h %h %0b", tag, o_eng_start, o_eng_data, o_rcp_x, o_sat_x, y, m_rx, m_sx);
        end
        if (stale) begin i_eng_done = 1'b1; i_eng_data = W'($urandom); i_eng_sat = 1'b1; end
        repeat (ly) begin
            @(negedge i_clk); cyc++;
            i_eng_done = 1'b0;
            if (hold) i_y = W'($urandom);
            checks++;
            if (o_eng_start !== 1'b0 || o_eng_data !== y || o_rcp_y !== m_ry || o_sat_y !== m_sy || o_rcp_x !== m_rx) begin
                errors++;
                $display("FAIL %s wait_y: start=%0b data=%h rcp_y=%h sat_y=%0b required 0 %h %h %0b", tag, o_eng_start, o_eng_data, o_rcp_y, o_sat_y, y, m_ry, m_sy);
            end
        end
        i_eng_done = 1'b1; i_eng_data = ey[W-1:0]; i_eng_sat = ey[W];
        @(negedge i_clk); cyc++;
        i_eng_done = 1'b0;
        m_ry = ey[W-1:0]; m_sy = ey[W];
        checks++;
        if (o_done !== 1'b1 || o_busy !== 1'b0 || cyc != lx + ly + 3) begin
            errors++;
            $display("FAIL %s done: done=%0b busy=%0b latency=%0d required 1 0 %0d", tag, o_done, o_busy, cyc, lx + ly + 3);
        end
        checks++;
        if (o_rcp_x !== m_rx || o_sat_x !== m_sx || o_rcp_y !== m_ry || o_sat_y !== m_sy) begin
            errors++;
            $display("FAIL %s results: x=%h/%0b y=%h/%0b required x=%h/%0b y=%h/%0b", tag, o_rcp_x, o_sat_x, o_rcp_y, o_sat_y, m_rx, m_sx, m_ry, m_sy);
        end
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0; i_start = 1'b0; i_x = '0; i_y = '0;
        i_eng_data = '0; i_eng_sat = 1'b0; i_eng_done = 1'b0;
        m_rx = '0; m_ry = '0; m_sx = 1'b0; m_sy = 1'b0;
        repeat (3) @(negedge i_clk);
        checks++;
        if ({o_busy, o_rcp_x, o_rcp_y, o_sat_x, o_sat_y, o_done, o_timeout, o_eng_start, o_eng_data} !== '0 || o_eng_abs !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs: busy=%0b rx=%h ry=%h done=%0b start=%0b data=%h abs=%0b required all 0, abs=1", o_busy, o_rcp_x, o_rcp_y, o_done, o_eng_start, o_eng_data, o_eng_abs);
        end
        i_reset_n = 1'b1;
        @(negedge i_clk);
    endtask

    task automatic test_basic();
        int s0, d0;
        s0 = n_start; d0 = n_done;
        do_req(24'h002000, 24'h004000, 3, 2, 1'b0, 1'b0, "basic");
        @(negedge i_clk);
        checks++;
        if (o_rcp_x !== 24'h000800 || o_rcp_y !== 24'h000400 || o_sat_x !== 1'b0 || o_sat_y !== 1'b0) begin
            errors++;
            $display("FAIL basic_values: x=%h y=%h sx=%0b sy=%0b required 000800 000400 0 0", o_rcp_x, o_rcp_y, o_sat_x, o_sat_y);
        end
        checks++;
        if (n_start - s0 != 2 || n_done - d0 != 1) begin
            errors++;
            $display("FAIL basic_pulses: starts=%0d dones=%0d required 2 1", n_start - s0, n_done - d0);
        end
    endtask

    task automatic test_saturation();
        do_req(24'h000001, 24'h001000, 2, 4, 1'b0, 1'b0, "sat");
        checks++;
        if (o_sat_x !== 1'b1 || o_rcp_x !== RCP_MAX_POS || o_rcp_y !== 24'h001000 || o_sat_y !== 1'b0) begin
            errors++;
            $display("FAIL sat_values: x=%h sx=%0b y=%h sy=%0b required %h 1 001000 0", o_rcp_x, o_sat_x, o_rcp_y, o_sat_y, RCP_MAX_POS);
        end
        @(negedge i_clk);
    endtask

    task automatic test_random();
        for (int k = 0; k < 10; k++) begin
            do_req(W'($urandom), W'($urandom), int'($urandom_range(1, 6)), int'($urandom_range(1, 6)), 1'b0, 1'b0, "random");
            repeat ($urandom_range(0, 2)) @(negedge i_clk);
        end
    endtask

    task automatic test_back_to_back();
        int s0, d0;
        s0 = n_start; d0 = n_done;
        for (int k = 0; k < 3; k++)
            do_req(W'($urandom), W'($urandom), 2, 3, 1'b1, 1'b0, "b2b");
        i_start = 1'b0;
        @(negedge i_clk);
        checks++;
        if (n_start - s0 != 6 || n_done - d0 != 3 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_pulses: starts=%0d dones=%0d busy=%0b required 6 3 0", n_start - s0, n_done - d0, o_busy);
        end
    endtask

    task automatic test_stale_done();
        int s0;
        s0 = n_start;
        i_eng_done = 1'b1; i_eng_sat = 1'b1;
        repeat (3) begin
            i_eng_data = W'($urandom);
            @(negedge i_clk);
            checks++;
            if (o_rcp_x !== m_rx || o_rcp_y !== m_ry || o_busy !== 1'b0 || o_done !== 1'b0 || o_eng_start !== 1'b0) begin
                errors++;
                $display("FAIL stale_idle: x=%h y=%h busy=%0b done=%0b required %h %h 0 0", o_rcp_x, o_rcp_y, o_busy, o_done, m_rx, m_ry);
            end
        end
        i_eng_done = 1'b0;
        checks++;
        if (n_start != s0) begin
            errors++;
            $display("FAIL stale_idle_start: starts=%0d required %0d", n_start, s0);
        end
        do_req(W'($urandom), W'($urandom), 1, 3, 1'b0, 1'b1, "stale");
        @(negedge i_clk);
    endtask

    task automatic test_reset_midop();
        logic [W:0] ex;
        int d0;
        logic [W-1:0] x, y;
        x = W'($urandom); y = W'($urandom); ex = eng_model(x);
        i_x = x; i_y = y; i_start = 1'b1;
        @(negedge i_clk); i_start = 1'b0;
        @(negedge i_clk);
        i_eng_done = 1'b1; i_eng_data = ex[W-1:0]; i_eng_sat = ex[W];
        @(negedge i_clk); i_eng_done = 1'b0;
        @(negedge i_clk);
        checks++;
        if (o_busy !== 1'b1 || o_eng_data !== y || o_rcp_x !== ex[W-1:0]) begin
            errors++;
            $display("FAIL midop_wait_y: busy=%0b data=%h rx=%h required 1 %h %h", o_busy, o_eng_data, o_rcp_x, y, ex[W-1:0]);
        end
        d0 = n_done;
        #2 i_reset_n = 1'b0;
        #1;
        checks++;
        if ({o_busy, o_rcp_x, o_rcp_y, o_sat_x, o_sat_y, o_done, o_timeout, o_eng_start, o_eng_data} !== '0) begin
            errors++;
            $display("FAIL midop_async_reset: busy=%0b rx=%h ry=%h start=%0b data=%h required all 0", o_busy, o_rcp_x, o_rcp_y, o_eng_start, o_eng_data);
        end
        m_rx = '0; m_ry = '0; m_sx = 1'b0; m_sy = 1'b0;
        repeat (3) @(negedge i_clk);
        i_reset_n = 1'b1;
        repeat (2) @(negedge i_clk);
        checks++;
        if (n_done != d0) begin
            errors++;
            $display("FAIL midop_no_done: dones=%0d required %0d", n_done, d0);
        end
        do_req(W'($urandom), W'($urandom), 2, 2, 1'b0, 1'b0, "after_reset");
        @(negedge i_clk);
    endtask

`ifdef RCP_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int early, t0;
        t0 = n_timeout;
        i_eng_done = 1'b0;
        i_x = W'($urandom); i_y = W'($urandom); i_start = 1'b1;
        early = 0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge i_clk);
            if (c == 1) i_start = 1'b0;
            if (o_timeout) early++;
        end
        @(negedge i_clk);
        m_rx = RCP_MAX_POS; m_sx = 1'b1;
        checks++;
        if (early != 0 || o_timeout !== 1'b1 || o_rcp_x !== m_rx || o_sat_x !== 1'b1 || o_eng_start !== 1'b1) begin
            errors++;
            $display("FAIL timeout_x: early=%0d to=%0b rx=%h sx=%0b start=%0b required 0 1 %h 1 1", early, o_timeout, o_rcp_x, o_sat_x, o_eng_start, m_rx);
        end
        early = 0;
        for (int c = 11; c <= 18; c++) begin
            @(negedge i_clk);
            if (o_timeout || o_done) early++;
        end
        @(negedge i_clk);
        m_ry = RCP_MAX_POS; m_sy = 1'b1;
        checks++;
        if (early != 0 || o_timeout !== 1'b1 || o_done !== 1'b1 || o_rcp_y !== m_ry || o_sat_y !== 1'b1) begin
            errors++;
            $display("FAIL timeout_y: early=%0d to=%0b done=%0b ry=%h sy=%0b required 0 1 1 %h 1", early, o_timeout, o_done, o_rcp_y, o_sat_y, m_ry);
        end
        i_eng_done = 1'b1; i_eng_data = W'($urandom);
        repeat (2) @(negedge i_clk);
        i_eng_done = 1'b0;
        checks++;
        if (n_timeout - t0 != 2 || o_rcp_y !== m_ry || o_rcp_x !== m_rx) begin
            errors++;
            $display("FAIL timeout_late_done: pulses=%0d ry=%h rx=%h required 2 %h %h", n_timeout - t0, o_rcp_y, o_rcp_x, m_ry, m_rx);
        end
    endtask
`endif

    task automatic test_pulse_rules();
        checks++;
        if (n_consec != 0) begin
            errors++;
            $display("FAIL eng_start_consecutive: count=%0d required 0", n_consec);
        end
`ifndef RCP_SEQ_TIMEOUT_EN
        checks++;
        if (n_timeout != 0) begin
            errors++;
            $display("FAIL timeout_tied_low: pulses=%0d required 0", n_timeout);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_random();
        test_back_to_back();
        test_stale_done();
        test_reset_midop();
`ifdef RCP_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        test_pulse_rules();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rcp_pair_sequencer.md
Name: rcp_pair_sequencer

Overview:
- Initiator side of the reciprocal_fsm start/data/done handshake.
- Accepts one request carrying two Q-format operands (ray direction X and Y).
- Issues them one after the other to a single shared reciprocal_fsm instance, captures both results and saturation flags, then pulses done.
- Sits between the ray-direction stage and the DDA setup. This lets one reciprocal engine serve both axes.

Parameters:
- M, 12, integer bits of the Q format (matches reciprocal_fsm M).
- N, 12, fractional bits of the Q format (matches reciprocal_fsm N).
- ABS, 1, value driven on o_eng_abs. 1 means the engine computes the reciprocal of |x|.
- TIMEOUT, 64, maximum wait cycles per operand. Used only when RCP_SEQ_TIMEOUT_EN is defined.

Ports:
- i_clk  in  1  system clock.
- i_reset_n  in  1  reset, asynchronous and active-low.
- i_start  in  1  request strobe; sampled only in IDLE or DONE.
- i_x  in  M+N  X operand (signed Q M.N).
- i_y  in  M+N  Y operand (signed Q M.N).
- o_busy  out  1  high from the cycle after acceptance until the DONE state.
- o_rcp_x  out  M+N  1/X result.
- o_rcp_y  out  M+N  1/Y result.
- o_sat_x  out  1  engine saturated on X.
- o_sat_y  out  1  engine saturated on Y.
- o_done  out  1  one-cycle pulse when both results are valid.
- o_timeout  out  1  one-cycle pulse on watchdog abort. Tied 0 without the macro.
- o_eng_start  out  1  to reciprocal_fsm i_start; a one-cycle pulse.
- o_eng_data  out  M+N  to reciprocal_fsm i_data.
- o_eng_abs  out  1  to reciprocal_fsm i_abs; constant ABS.
- i_eng_data  in  M+N  from reciprocal_fsm o_data.
- i_eng_sat  in  1  from reciprocal_fsm o_sat.
- i_eng_done  in  1  from reciprocal_fsm o_done.

Behaviour:
- Reset (i_reset_n low, async): state=IDLE; all outputs 0; operand latches 0. Reset mid-operation discards the request; no o_done is produced.
- States: IDLE, ISSUE_X, WAIT_X, ISSUE_Y, WAIT_Y, DONE.
- IDLE/DONE with i_start=1: latch i_x and i_y, go to ISSUE_X. i_start in any other state is ignored, with no queueing.
- ISSUE_X: o_eng_start=1 and o_eng_data=latched X for exactly one cycle, then WAIT_X.
- WAIT_X: o_eng_data holds X. On i_eng_done, register i_eng_data into o_rcp_x and i_eng_sat into o_sat_x, then go to ISSUE_Y.
- ISSUE_Y and WAIT_Y mirror the X states, using Y and writing o_rcp_y / o_sat_y. On i_eng_done go to DONE.
- DONE: o_done=1 for this single cycle, o_busy=0. Next state is ISSUE_X if i_start is high, else IDLE. Back-to-back requests are therefore permitted.
- i_eng_done is ignored in IDLE, ISSUE_X, ISSUE_Y and DONE. This blocks stale engine completions.
- Each of o_rcp_x, o_rcp_y, o_sat_x and o_sat_y changes only at its own capture edge and otherwise holds its value.
- o_eng_start is registered and never high on two consecutive cycles.
- Minimum latency from i_start to o_done is 2×(engine latency) + 3 cycles.
- No arithmetic in the block; widths pass straight through (M+N bits).

Optional Feature:
- Macro: RCP_SEQ_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to each WAIT state.
  - If it reaches TIMEOUT without i_eng_done, the current result is forced to the maximum positive value (0 sign bit, all other bits 1) with its sat flag set to 1.
  - o_timeout pulses for one cycle and the FSM advances as if done had arrived.
  - A late i_eng_done is then ignored under the same per-state rule.
- Not defined: no counter; the WAIT states wait indefinitely; o_timeout is constant 0.

Decomposition:
- Shared package rcp_pkg holds:
  - the Q-format width constant (M+N) and max-positive constant;
  - the state enumeration for rcp_pair_sequencer;
  - the default TIMEOUT.
- No sub-module: the watchdog is a few lines inline.
- reciprocal_fsm is instantiated by the parent, not inside this block.

Test Plan:
- Basic: i_x=24'h002_000 (2.0), i_y=24'h004_000 (4.0), pulse i_start, real reciprocal_fsm attached. Required: o_rcp_x=24'h000_800, o_rcp_y=24'h000_400, both sat=0, exactly one o_done, exactly two o_eng_start pulses (X first).
- Saturation: i_x=24'h000_001, i_y=24'h001_000. Required: o_sat_x=1, o_rcp_y=24'h001_000 with o_sat_y=0.
- Busy/back-to-back: i_start held high throughout. Required: starts ignored while busy, new request accepted in the DONE cycle, second o_done after exactly the same latency as the first.
- Stale done: behavioural engine drives i_eng_done in IDLE and during ISSUE_X. Required: results unchanged, no state advance.
- Reset mid-op: drop i_reset_n during WAIT_Y. Required: all outputs 0 immediately, no o_done, next request completes normally.
- Timeout (macro defined, TIMEOUT=8): engine never asserts done. Required: o_timeout pulses 8 cycles after WAIT_X entry, o_rcp_x=24'h7FF_FFF with o_sat_x=1, then Y times out likewise, then o_done.
